bch_correct_buffer: RTL and testbench

Correction stage placed directly downstream of the BCH error locator (`bch_error_dec` / `bch_error_tmec`). It stores the received data bits of each codeword, arriving in parallel with the syndrome stage, while decoding proceeds. It replays each stored word XORed with the locator's `err` stream and emits corrected data. It holds up to FRAMES codewords in flight and flags protocol violations with sticky flags.

---
 rtl/bch_correct_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_bch_correct_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_correct_buffer.sv
// ---------------------------------------------------------------------------
// bch_correct_buffer
//
// Correction stage that sits behind the BCH error locator. Received data bits
// of each codeword are written into a circular buffer while the syndrome and
// locator stages work on the same codeword. When the locator streams the error
// vector, each stored word is read back, XORed with the error bits and emitted.
// Up to FRAMES codewords may be held at once. Protocol violations raise sticky
// flags that only reset clears.
//
// Parameters:
//   DATA_BITS  data bits per codeword (must be a multiple of BITS)
//   BITS       bits per word on every stream
//   FRAMES     codewords of storage (>= 1)
//
// Ports:
//   clk        clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   wr_first   first data word of a received codeword
//   wr_valid   wr_data valid this cycle
//   wr_data    received data word, LSB-first within the codeword
//   wr_ready   a word presented now will be accepted
//   err_first  locator: first word of the error vector
//   err_valid  locator: err valid (never stalled)
//   err_last   locator: last word of the error vector
//   err        locator: error bits for the current word
//   out_valid  corrected word valid
//   out_first  first word of a corrected frame
//   out_last   last word of a corrected frame
//   out_data   stored word XOR err
//   frames     complete frames held (not yet fully read)
//   overflow   sticky: write attempted while wr_ready = 0
//   underflow  sticky: err_valid with no complete frame available
//   sync_err   sticky: write or read framing violation
// ---------------------------------------------------------------------------
module bch_correct_buffer #(
    parameter int DATA_BITS = 32,
    parameter int BITS      = 1,
    parameter int FRAMES    = 2,
    localparam int W        = DATA_BITS / BITS,
    localparam int FW       = $clog2(FRAMES + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_first,
    input  logic            wr_valid,
    input  logic [BITS-1:0] wr_data,
    output logic            wr_ready,
    input  logic            err_first,
    input  logic            err_valid,
    input  logic            err_last,
    input  logic [BITS-1:0] err,
    output logic            out_valid,
    output logic            out_first,
    output logic            out_last,
    output logic [BITS-1:0] out_data,
    output logic [FW-1:0]   frames,
    output logic            overflow,
    output logic            underflow,
    output logic            sync_err
);

    localparam int DEPTH = FRAMES * W;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(W + 1);

    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(W - 1);
    localparam logic [CW-1:0] W_C       = CW'(W);
    localparam logic [FW-1:0] FRAMES_C  = FW'(FRAMES);

    if ((DATA_BITS % BITS) != 0 || W < 1 || FRAMES < 1) begin : g_param_check
        $error("bch_correct_buffer: DATA_BITS must be a positive multiple of BITS and FRAMES >= 1");
    end

    // Circular word storage.
    logic [BITS-1:0] mem [DEPTH];

    // Writer state: wr_base is the base of the frame being written; it equals
    // wr_ptr whenever wr_word is 0, so a wr_first word always lands on it.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_base;
    logic [CW-1:0] wr_word;

    // Reader state.
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] rd_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Space exists for a new frame only if fewer than FRAMES are complete;
    // a frame already in progress always has its slot reserved.
    assign wr_ready = (wr_word != '0) || (frames < FRAMES_C);

    // ---------------- write decode ----------------
    logic          wr_accept;
    logic          wr_store;
    logic          wr_complete;
    logic          wr_resync;
    logic [PW-1:0] wr_addr;
    logic [CW-1:0] wr_count;

    assign wr_accept = wr_valid && wr_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        wr_store    = 1'b0;
        wr_complete = 1'b0;
        wr_resync   = 1'b0;
        wr_addr     = wr_ptr;
        wr_count    = wr_word;
        if (wr_accept) begin
            if (wr_first) begin
                // A restart mid-frame discards the partial frame by rewinding
                // to its base.
                wr_store  = 1'b1;
                wr_addr   = wr_base;
                wr_count  = CW'(1);
                wr_resync = (wr_word != '0);
            end else if (wr_word == '0) begin
                // Continuation word with no frame open: dropped.
                wr_resync = 1'b1;
            end else begin
                wr_store = 1'b1;
                wr_count = wr_word + 1'b1;
            end
            wr_complete = wr_store && (wr_count == W_C);
        end
    end

    // ---------------- read decode ----------------
    logic rd_empty;
    logic rd_fire;
    logic rd_at_first;
    logic rd_at_last;
    logic rd_done;
    logic rd_sync_bad;

    // rd_word != 0 implies the frame being read is still counted in frames.
    assign rd_empty    = (rd_word == '0) && (frames == '0);
    assign rd_fire     = err_valid && !rd_empty;
    assign rd_at_first = (rd_word == '0);
    assign rd_at_last  = (rd_word == LAST_WORD);
    assign rd_done     = rd_fire && rd_at_last;
    // Locator markers are only checked; the word count owns frame boundaries.
    assign rd_sync_bad = rd_fire && ((err_first != rd_at_first) || (err_last != rd_at_last));

    // NOTE: the storage array has no reset; its contents are never read
    // before being written because a frame must be complete to be read.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            wr_base   <= '0;
            wr_word   <= '0;
            rd_ptr    <= '0;
            rd_word   <= '0;
            frames    <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            // Writer.
            if (wr_store) begin
                wr_ptr  <= ptr_inc(wr_addr);
                wr_word <= wr_complete ? '0 : wr_count;
                if (wr_complete) begin
                    wr_base <= ptr_inc(wr_addr);
                end
            end

            // Reader.
            if (rd_fire) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                rd_word  <= rd_at_last ? '0 : rd_word + 1'b1;
                out_data <= mem[rd_ptr] ^ err;
            end
            out_valid <= rd_fire;
            out_first <= rd_fire && rd_at_first;
            out_last  <= rd_fire && rd_at_last;

            // Complete-frame count; simultaneous completion and read-out cancel.
            if (wr_complete && !rd_done) begin
                frames <= frames + 1'b1;
            end else if (!wr_complete && rd_done) begin
                frames <= frames - 1'b1;
            end

            // Sticky flags.
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (err_valid && rd_empty) begin
                underflow <= 1'b1;
            end
            if (wr_resync || rd_sync_bad) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bch_correct_buffer.sv
// ---------------------------------------------------------------------------
// tb_bch_correct_buffer
//
// Directed bench for bch_correct_buffer with DATA_BITS=32, BITS=4, FRAMES=2
// (8 words per frame). Frames written by the bench are kept in a queue of
// 32-bit codewords; when a frame is read the bench derives each expected
// corrected word from that codeword and the error vector it drives, and
// pushes it to a scoreboard that a negedge monitor pops on out_valid.
// ---------------------------------------------------------------------------
module tb_bch_correct_buffer;

    localparam int DATA_BITS = 32;
    localparam int BITS      = 4;
    localparam int FRAMES    = 2;
    localparam int W         = DATA_BITS / BITS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_first, wr_valid, wr_ready;
    logic [3:0] wr_data;
    logic       err_first, err_valid, err_last;
    logic [3:0] err;
    logic       out_valid, out_first, out_last;
    logic [3:0] out_data;
    logic [1:0] frames;
    logic       overflow, underflow, sync_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [3:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame_q[$];

    bch_correct_buffer #(
        .DATA_BITS(DATA_BITS),
        .BITS     (BITS),
        .FRAMES   (FRAMES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_first (wr_first),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .err_first(err_first),
        .err_valid(err_valid),
        .err_last (err_last),
        .err      (err),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last (out_last),
        .out_data (out_data),
        .frames   (frames),
        .overflow (overflow),
        .underflow(underflow),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_word", 32'({out_first, out_last, out_data}), 32'(e));
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic wv, input logic wf, input logic [3:0] wd,
                        input logic ev, input logic ef, input logic el, input logic [3:0] e);
        wr_valid  = wv;
        wr_first  = wf;
        wr_data   = wd;
        err_valid = ev;
        err_first = ef;
        err_last  = el;
        err       = e;
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        wr_first  = 1'b0;
        wr_data   = 4'h0;
        err_valid = 1'b0;
        err_first = 1'b0;
        err_last  = 1'b0;
        err       = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Write a full frame; keep=0 for frames expected to be dropped.
    task automatic write_frame(input logic [31:0] d, input bit keep);
        logic [31:0] dv;
        dv = d;
        for (int i = 0; i < W; i++) step(1'b1, i == 0, dv[i*4 +: 4], 1'b0, 1'b0, 1'b0, 4'h0);
        if (keep) frame_q.push_back(dv);
    endtask

    // Read the oldest frame with error vector e; err_last is driven on word
    // last_at; chk_ready checks wr_ready after each word when the buffer was full.
    task automatic read_frame(input logic [31:0] e, input int last_at, input bit chk_ready,
                              input int nwords);
        logic [31:0] g;
        logic [31:0] ev;
        exp_t        x;
        ev = e;
        g  = frame_q.pop_front();
        for (int i = 0; i < nwords; i++) begin
            x.first = (i == 0);
            x.last  = (i == W - 1);
            x.data  = g[i*4 +: 4] ^ ev[i*4 +: 4];
            exp_q.push_back(x);
            step(1'b0, 1'b0, 4'h0, 1'b1, i == 0, i == last_at, ev[i*4 +: 4]);
            if (chk_ready) check("ready_during_read", 32'(wr_ready), 32'(i == W - 1));
        end
    endtask

    // Write frame wd while reading the oldest frame, word-aligned.
    task automatic rw_frame(input logic [31:0] wd, input logic [31:0] e);
        logic [31:0] g;
        logic [31:0] wv;
        logic [31:0] ev;
        exp_t        x;
        wv = wd;
        ev = e;
        g  = frame_q.pop_front();
        for (int i = 0; i < W; i++) begin
            x.first = (i == 0);
            x.last  = (i == W - 1);
            x.data  = g[i*4 +: 4] ^ ev[i*4 +: 4];
            exp_q.push_back(x);
            step(1'b1, i == 0, wv[i*4 +: 4], 1'b1, i == 0, i == W - 1, ev[i*4 +: 4]);
        end
        frame_q.push_back(wv);
    endtask

    initial begin
        wr_first = 1'b0; wr_valid = 1'b0; wr_data = 4'h0;
        err_first = 1'b0; err_valid = 1'b0; err_last = 1'b0; err = 4'h0;

        // Reset state.
        apply_reset();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_first", 32'(out_first), 32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_frames",    32'(frames),    32'(0));
        check("rst_flags",     32'({overflow, underflow, sync_err}), 32'(0));
        check("rst_wr_ready",  32'(wr_ready),  32'(1));

        // Basic correction: 0xDEADBEEF with a single-bit error in word 0.
        write_frame(32'hDEADBEEF, 1'b1);
        check("basic_frames_1", 32'(frames), 32'(1));
        read_frame(32'h0000_0001, W - 1, 1'b0, W);
        idle(2);
        check("basic_frames_0", 32'(frames), 32'(0));

        // Fill both slots, overflow on the third frame, then drain.
        write_frame(32'h12345678, 1'b1);
        check("fill_ready_1", 32'(wr_ready), 32'(1));
        write_frame(32'h9ABCDEF0, 1'b1);
        check("full_frames", 32'(frames), 32'(2));
        check("full_ready", 32'(wr_ready), 32'(0));
        check("full_no_ovf", 32'(overflow), 32'(0));
        write_frame(32'h0F1E2D3C, 1'b0);
        check("ovf_set", 32'(overflow), 32'(1));
        check("ovf_frames", 32'(frames), 32'(2));
        read_frame(32'h0, W - 1, 1'b1, W);
        check("drain_frames_1", 32'(frames), 32'(1));
        read_frame(32'h5A5A5A5A, W - 1, 1'b0, W);
        idle(2);
        check("drain_frames_0", 32'(frames), 32'(0));

        // Concurrent last read and last write.
        apply_reset();
        check("rst_clears_ovf", 32'(overflow), 32'(0));
        write_frame(32'hCAFEF00D, 1'b1);
        rw_frame(32'h01234567, 32'h80000008);
        check("rw_frames", 32'(frames), 32'(1));
        check("rw_flags", 32'({overflow, underflow, sync_err}), 32'(0));
        read_frame(32'h0, W - 1, 1'b0, W);
        idle(2);
        check("rw_frames_0", 32'(frames), 32'(0));

        // Underflow, then a misplaced err_last.
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h3);
        check("udf_no_out", 32'(out_valid), 32'(0));
        check("udf_set", 32'(underflow), 32'(1));
        check("udf_no_sync", 32'(sync_err), 32'(0));
        write_frame(32'h76543210, 1'b1);
        read_frame(32'h00F00000, 5, 1'b0, W);
        idle(2);
        check("early_last_sync", 32'(sync_err), 32'(1));
        check("early_last_frames", 32'(frames), 32'(0));
        write_frame(32'hA5C3E187, 1'b1);
        read_frame(32'h0, W - 1, 1'b0, W);
        idle(2);

        // Restart mid-frame.
        apply_reset();
        step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0);
        check("partial_no_sync", 32'(sync_err), 32'(0));
        write_frame(32'h13579BDF, 1'b1);
        check("restart_sync", 32'(sync_err), 32'(1));
        check("restart_frames", 32'(frames), 32'(1));
        read_frame(32'h0, W - 1, 1'b0, W);
        idle(2);

        // Wrap: five frames through two slots, all-ones error vector.
        apply_reset();
        write_frame(32'h00000000, 1'b1);
        write_frame(32'h11112222, 1'b1);
        read_frame(32'hFFFFFFFF, W - 1, 1'b0, W);
        write_frame(32'h3C3C5A5A, 1'b1);
        read_frame(32'hFFFFFFFF, W - 1, 1'b0, W);
        write_frame(32'h89ABCDEF, 1'b1);
        read_frame(32'hFFFFFFFF, W - 1, 1'b0, W);
        write_frame(32'hF0E1D2C3, 1'b1);
        read_frame(32'hFFFFFFFF, W - 1, 1'b0, W);
        read_frame(32'hFFFFFFFF, W - 1, 1'b0, W);
        idle(2);
        check("wrap_frames", 32'(frames), 32'(0));
        check("wrap_flags", 32'({overflow, underflow, sync_err}), 32'(0));
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        // Reset asserted mid-read clears outputs immediately.
        write_frame(32'h2468ACE0, 1'b1);
        read_frame(32'h0, W - 1, 1'b0, 4);
        check("pre_reset_out_valid", 32'(out_valid), 32'(1));
        check("pre_reset_frames", 32'(frames), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'(0));
        check("async_rst_frames", 32'(frames), 32'(0));
        exp_q.delete();
        frame_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
